// File: rtl/alu_seq_consumer.sv
// Consumer side of the keypad operand handshake: samples a/b on a start_alu
// rising edge and runs add/sub in one cycle, or mul/div as W-step datapaths.
module alu_seq_consumer #(
    parameter int W = 4
) (
    input  logic           clk_50HZ,
    input  logic           rst,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     op,
    input  logic           start_alu,
    output logic [2*W-1:0] result,
    output logic [W-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [3:0]     alu_current_state
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        CALC = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t state, state_nx;

    logic           start_d;
    logic [W-1:0]   a_r, b_r;
    logic [1:0]     op_r;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc, mcand, acc_nx;
    logic [W-1:0]   mplier;
    logic [W-1:0]   quo, dvd, rem_r;
    logic [W:0]     trial;
    logic [W-1:0]   diff, rem_nx, quo_nx;
    logic           qbit, last, div0, start;

    assign start = start_alu & ~start_d;
    assign last  = (cnt == CW'(W - 1));
    assign div0  = (op_r == 2'b11) && (b_r == '0);

    // One shift-add step and one restoring-division step per CALC cycle
    always_comb begin
        acc_nx = acc + (mplier[0] ? mcand : '0);
        trial  = {rem_r, dvd[W-1]};
        qbit   = (trial >= {1'b0, b_r});
        diff   = trial[W-1:0] - b_r;
        rem_nx = qbit ? diff : trial[W-1:0];
        quo_nx = {quo[W-2:0], qbit};
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = div0 ? DONE : CALC;
            CALC:    if (!op_r[1] || last) state_nx = DONE;
            DONE:    if (!start_alu) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_50HZ) begin
        if (!rst) begin
            state     <= IDLE;
            start_d   <= 1'b1;
            result    <= '0;
            remainder <= '0;
            err       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            quo       <= '0;
            dvd       <= '0;
            rem_r     <= '0;
        end else begin
            state   <= state_nx;
            start_d <= start_alu;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        op_r <= op;
                    end
                end
                LOAD: begin
                    err    <= 1'b0;
                    cnt    <= '0;
                    acc    <= '0;
                    mcand  <= {{W{1'b0}}, a_r};
                    mplier <= b_r;
                    quo    <= '0;
                    dvd    <= a_r;
                    rem_r  <= '0;
                    if (div0) begin
                        err       <= 1'b1;
                        result    <= '1;
                        remainder <= a_r;
                    end
                end
                CALC: begin
                    cnt    <= cnt + CW'(1);
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    quo    <= quo_nx;
                    dvd    <= dvd << 1;
                    rem_r  <= rem_nx;
                    // Outputs change only on the exiting cycle
                    unique case (op_r)
                        2'b00: begin
                            result    <= {{W{1'b0}}, a_r} + {{W{1'b0}}, b_r};
                            remainder <= '0;
                        end
                        2'b01: begin
                            result    <= {{W{1'b0}}, a_r} - {{W{1'b0}}, b_r};
                            remainder <= '0;
                        end
                        2'b10: begin
                            if (last) begin
                                result    <= acc_nx;
                                remainder <= '0;
                            end
                        end
                        default: begin
                            if (last) begin
                                result    <= {{W{1'b0}}, quo_nx};
                                remainder <= rem_nx;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign busy              = (state == LOAD) || (state == CALC);
    assign done              = (state == DONE);
    assign alu_current_state = state;

endmodule

// File: tb/tb_alu_seq_consumer.sv
// Scoreboard bench for alu_seq_consumer: directed operations push expected
// results; a monitor pops and compares on every done rising edge.
module tb_alu_seq_consumer;

    localparam int W = 4;

    logic           clk_50HZ = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [1:0]     op = '0;
    logic           start_alu = 1'b0;
    logic [2*W-1:0] result;
    logic [W-1:0]   remainder;
    logic           busy, done, err;
    logic [3:0]     alu_current_state;

    typedef struct {
        logic [2*W-1:0] res;
        logic [W-1:0]   rem;
        logic           err;
        int             cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic done_q = 1'b0;

    alu_seq_consumer #(.W(W)) dut (
        .clk_50HZ(clk_50HZ),
        .rst(rst),
        .a(a),
        .b(b),
        .op(op),
        .start_alu(start_alu),
        .result(result),
        .remainder(remainder),
        .busy(busy),
        .done(done),
        .err(err),
        .alu_current_state(alu_current_state)
    );

    always #10 clk_50HZ = ~clk_50HZ;

    always @(posedge clk_50HZ) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_50HZ) begin
        chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
        if (done && !done_q) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %0h want none",
                         result);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", result, mon_e.res);
                chk("remainder", remainder, mon_e.rem);
                chk("err", err, mon_e.err);
                chk("latency", cyc, mon_e.cyc);
            end
        end
        done_q = done;
    end

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [1:0] opv, input logic [2*W-1:0] er,
                          input logic [W-1:0] em, input logic ee,
                          input int lat, input bit drop_mid);
        exp_t e;
        int   bc;
        bit   seen;
        @(negedge clk_50HZ);
        a         = av;
        b         = bv;
        op        = opv;
        start_alu = 1'b1;
        e.res     = er;
        e.rem     = em;
        e.err     = ee;
        e.cyc     = cyc + 1 + lat;
        sbq.push_back(e);
        bc   = 0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_50HZ);
            a  = ~av;
            b  = ~bv;
            op = ~opv;
            if (drop_mid && n == 2) start_alu = 1'b0;
            if (done) seen = 1'b1;
            else if (busy) bc++;
        end
        chk("done_timeout", {31'b0, seen}, 32'd1);
        chk("busy_cycles", bc, lat);
        if (!drop_mid) begin
            repeat (2) @(negedge clk_50HZ);
            chk("hold_done", {31'b0, done}, 32'd1);
            chk("hold_result", result, er);
            start_alu = 1'b0;
        end
        @(negedge clk_50HZ);
        chk("back_idle", alu_current_state, 32'b0001);
        chk("done_low", {31'b0, done}, 32'd0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_state"}, alu_current_state, 32'b0001);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_rem"}, remainder, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start_alu = 1'b1;
        repeat (2) @(negedge clk_50HZ);
        chk_cleared("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk_50HZ);
        chk("no_start_state", alu_current_state, 32'b0001);
        chk("no_start_done", {31'b0, done}, 32'd0);
        start_alu = 1'b0;

        run_op(4'd9, 4'd7, 2'b00, 8'h10, 4'd0, 1'b0, 2, 1'b0);
        run_op(4'd3, 4'd5, 2'b01, 8'hFE, 4'd0, 1'b0, 2, 1'b0);
        run_op(4'd15, 4'd15, 2'b10, 8'hE1, 4'd0, 1'b0, 5, 1'b0);
        run_op(4'd13, 4'd4, 2'b11, 8'h03, 4'd1, 1'b0, 5, 1'b0);
        run_op(4'd6, 4'd0, 2'b11, 8'hFF, 4'd6, 1'b1, 1, 1'b0);
        run_op(4'd7, 4'd6, 2'b10, 8'd42, 4'd0, 1'b0, 5, 1'b1);

        @(negedge clk_50HZ);
        a         = 4'd5;
        b         = 4'd9;
        op        = 2'b10;
        start_alu = 1'b1;
        repeat (3) @(negedge clk_50HZ);
        chk("midcalc_busy", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk_50HZ);
        chk_cleared("abort");
        rst       = 1'b1;
        start_alu = 1'b0;

        run_op(4'd2, 4'd3, 2'b10, 8'd6, 4'd0, 1'b0, 5, 1'b0);

        repeat (2) @(negedge clk_50HZ);
        chk("queue_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_consumer.md
Name: alu_seq_consumer

Overview:
- Consumer end of the two-operand keypad handshake.
- Samples operands a/b when start_alu rises, and executes add, subtract, multiply or divide.
- Multiply and divide run as sequential 4-iteration datapaths; add and subtract take one compute cycle.
- Holds the result and done until the producer drops start_alu. Results feed the display path.

Parameters:
- W, 4, operand width in bits. Result width is 2*W. The iteration count equals W.

Ports:
- clk_50HZ  input  1  system clock.
- rst  input  1  synchronous reset, active-low.
- a  input  W  operand A, valid while start_alu=1.
- b  input  W  operand B, valid while start_alu=1.
- op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- start_alu  input  1  level request from the input FSM.
- result  output  2W  add/sub/mul value, or quotient for div.
- remainder  output  W  div remainder; 0 for other ops.
- busy  output  1  high in LOAD and CALC.
- done  output  1  high in DONE.
- err  output  1  divide-by-zero flag.
- alu_current_state  output  4  one-hot state, for debug/LEDs.

Behaviour:
- Reset (rst=0 at a clk_50HZ edge) clears everything on that edge:
  - state=IDLE (0001); result=0, remainder=0, busy=0, done=0, err=0.
  - Iteration counter=0; internal operand/accumulator regs=0.
  - start_d=1, so a start_alu already high at reset release does NOT start an operation.
  - Reset mid-operation aborts it; no partial result is retained.
- Start detect: start_d <= start_alu every cycle. Start condition = start_alu & ~start_d, sampled only in IDLE.
- States, one-hot: IDLE 0001, LOAD 0010, CALC 0100, DONE 1000.
- IDLE:
  - On start, go to LOAD and capture a, b, op into internal regs.
  - result and remainder keep their last values; done=0.
- LOAD (1 cycle):
  - Clear err, counter and accumulators.
  - If op=11 and b=0: err<=1, result<=all ones, remainder<=a, go to DONE.
  - Otherwise go to CALC.
- CALC, add: result <= zero-extended a+b (max 30); go to DONE after 1 cycle.
- CALC, sub: result <= a-b as 2W-bit two's complement, with a and b treated as unsigned (3-5 = 8'hFE); 1 cycle.
- CALC, mul: shift-add, LSB of multiplier first, one bit per cycle, W cycles.
  - Counter counts 0..W-1; exits to DONE on the cycle counter=W-1.
  - result = a*b (15*15 = 225).
- CALC, div: restoring division, MSB first, W cycles.
  - result[W-1:0] = quotient, upper bits 0.
  - remainder = a mod b.
- result and remainder update only on the CALC exit (or the LOAD div-zero exit); intermediate values are never visible on the outputs.
- Latency, counted in edges after the edge that samples start (state enters LOAD):
  - add/sub: done after 2 edges.
  - mul/div: done after W+1 edges (5 for W=4).
  - div-by-zero: done after 1 edge.
- DONE:
  - done=1; result, remainder and err held stable.
  - Stay while start_alu=1; go to IDLE on the first cycle start_alu=0.
- start_alu dropping during LOAD/CALC is ignored. The operation completes, then DONE lasts exactly 1 cycle (done pulse) and returns to IDLE.
- Operand changes on a/b after the capture have no effect.
- A new rising edge of start_alu is accepted only from IDLE. Edges while busy or in DONE are not queued.
- busy and done are never high together.

Test Plan:
- Reset with start_alu=1, then release rst:
  - State stays 0001; done=0.
  - Drop start_alu, raise it again: operation starts.
- Add and sub:
  - op=00, a=9, b=7, start rises: done after 2 edges with result=8'h10, remainder=0, err=0.
  - op=01, a=3, b=5: result=8'hFE.
- Mul:
  - op=10, a=15, b=15: busy high for 5 cycles (LOAD plus 4 CALC).
  - Then done=1, result=8'hE1 (225); held while start_alu=1.
  - IDLE on the cycle after start_alu=0.
- Div and div-by-zero:
  - op=11, a=13, b=4: done after 5 edges; result=3, remainder=1.
  - op=11, a=6, b=0: done after 1 edge; err=1, result=8'hFF, remainder=6.
- start_alu dropped mid-CALC (mul, a=7, b=6):
  - result=42 still delivered.
  - done high exactly 1 cycle, then state 0001.
- rst=0 asserted during mul CALC:
  - Next edge: all outputs 0, state 0001.
  - A fresh start computes correctly (a=2, b=3, mul gives 6).
